// File: rtl/pong_pkg.sv
// Shared types and constants for the pong design: screen geometry, game and
// update-sequencer state encodings, and the signed position helper.
package pong_pkg;

   localparam int H_RES = 640;
   localparam int V_RES = 480;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      OVER  = 3'd3
   } game_state_t;

   typedef enum logic [2:0] {
      U_IDLE    = 3'd0,
      U_PADDLE  = 3'd1,
      U_BALL    = 3'd2,
      U_COLLIDE = 3'd3,
      U_COMMIT  = 3'd4
   } upd_state_t;

   // One extra bit over the stored 10-bit positions so under/overflow shows up.
   typedef logic signed [10:0] spos_t;

   function automatic logic [9:0] clamp_pos(input spos_t v, input spos_t hi);
      if (v[10]) begin
         return '0;
      end else if (v > hi) begin
         return hi[9:0];
      end else begin
         return v[9:0];
      end
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer bank for asynchronous push-button inputs.
module btn_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/pong_ctrl.sv
// Per-frame pong game controller: a short update sequence at each frame_tick
// moves paddles and ball, resolves collisions/scoring and commits the outputs.
module pong_ctrl
   import pong_pkg::*;
#(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 48,
   parameter int PADDLE_XL    = 16,
   parameter int PADDLE_XR    = 616,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic       clock_25M,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       btn_l_up,
   input  logic       btn_l_dn,
   input  logic       btn_r_up,
   input  logic       btn_r_dn,
   input  logic       btn_start,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] paddle_l_y,
   output logic [9:0] paddle_r_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic [2:0] game_state,
   output logic       update_done
);

   localparam spos_t SPD_B  = spos_t'(BALL_SPEED);
   localparam spos_t SPD_P  = spos_t'(PADDLE_SPEED);
   localparam spos_t BSZ    = spos_t'(BALL_SIZE);
   localparam spos_t PH     = spos_t'(PADDLE_H);
   localparam spos_t X_MAX  = spos_t'(H_RES - BALL_SIZE);
   localparam spos_t Y_MAX  = spos_t'(V_RES - BALL_SIZE);
   localparam spos_t P_MAX  = spos_t'(V_RES - PADDLE_H);
   localparam spos_t XL_HIT = spos_t'(PADDLE_XL + PADDLE_W);
   localparam spos_t XR_HIT = spos_t'(PADDLE_XR - BALL_SIZE);

   localparam logic [9:0] CX     = 10'((H_RES - BALL_SIZE) / 2);
   localparam logic [9:0] CY     = 10'((V_RES - BALL_SIZE) / 2);
   localparam logic [9:0] P_INIT = 10'((V_RES - PADDLE_H) / 2);
   localparam logic [3:0] WIN    = 4'(WIN_SCORE);

   localparam int                CNT_W    = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

   logic [4:0] btn_s;
   logic       start_s, l_up_s, l_dn_s, r_up_s, r_dn_s;

   upd_state_t  upd_q, upd_d;
   game_state_t state_q, state_d;

   logic [9:0]       ball_x_q, ball_y_q, pl_q, pr_q;
   logic [3:0]       score_l_q, score_r_q;
   logic             vx_neg_q, vy_neg_q, serve_neg_q;
   logic [CNT_W-1:0] cnt_q;

   logic [9:0] wpl_q, wpr_q;
   spos_t      wbx_q, wby_q;

   spos_t bx_c, by_c, old_x;
   logic  vxn_c, vyn_c, miss_l, miss_r;

   logic paddles_en, ball_live, restart, launch, score_pt;

   btn_sync #(.WIDTH(5)) u_btn_sync (
      .clk_i   (clock_25M),
      .rst_ni  (reset_n),
      .async_i ({btn_start, btn_r_dn, btn_r_up, btn_l_dn, btn_l_up}),
      .sync_o  (btn_s)
   );

   assign {start_s, r_dn_s, r_up_s, l_dn_s, l_up_s} = btn_s;

   function automatic logic [9:0] step_paddle(input logic [9:0] y, input logic up,
                                              input logic dn);
      spos_t n;
      n = $signed({1'b0, y});
      if (up && !dn) begin
         n = n - SPD_P;
      end else if (dn && !up) begin
         n = n + SPD_P;
      end
      return clamp_pos(n, P_MAX);
   endfunction

   function automatic logic overlap(input spos_t by, input logic [9:0] py);
      spos_t p;
      p = $signed({1'b0, py});
      return ((by + BSZ) > p) && (by < (p + PH));
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= WIN) ? s : s + 4'd1;
   endfunction

   always_ff @(posedge clock_25M or negedge reset_n) begin
      if (!reset_n) begin
         upd_q <= U_IDLE;
      end else begin
         upd_q <= upd_d;
      end
   end

   // A tick arriving mid-sequence is dropped because only U_IDLE looks at it.
   always_comb begin
      upd_d = upd_q;
      case (upd_q)
         U_IDLE:    if (frame_tick) upd_d = U_PADDLE;
         U_PADDLE:  upd_d = U_BALL;
         U_BALL:    upd_d = U_COLLIDE;
         U_COLLIDE: upd_d = U_COMMIT;
         default:   upd_d = U_IDLE;
      endcase
   end

   always_ff @(posedge clock_25M or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (upd_q == U_COLLIDE) begin
         case (state_q)
            IDLE:  if (start_s) state_d = SERVE;
            SERVE: if (cnt_q == CNT_LAST) state_d = PLAY;
            PLAY: begin
               if (miss_l) begin
                  state_d = (sat_inc(score_r_q) == WIN) ? OVER : SERVE;
               end else if (miss_r) begin
                  state_d = (sat_inc(score_l_q) == WIN) ? OVER : SERVE;
               end
            end
            OVER:  if (start_s) state_d = SERVE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      paddles_en = (state_q == SERVE) || (state_q == PLAY);
      ball_live  = (state_q == PLAY);
      restart    = 1'b0;
      launch     = 1'b0;
      score_pt   = 1'b0;
      if (upd_q == U_COLLIDE) begin
         restart  = ((state_q == IDLE) || (state_q == OVER)) && start_s;
         launch   = (state_q == SERVE) && (cnt_q == CNT_LAST);
         score_pt = ball_live && (miss_l || miss_r);
      end
   end

   always_ff @(posedge clock_25M or negedge reset_n) begin
      if (!reset_n) begin
         wpl_q <= P_INIT;
         wpr_q <= P_INIT;
         wbx_q <= $signed({1'b0, CX});
         wby_q <= $signed({1'b0, CY});
      end else begin
         case (upd_q)
            U_PADDLE: begin
               wpl_q <= paddles_en ? step_paddle(pl_q, l_up_s, l_dn_s) : pl_q;
               wpr_q <= paddles_en ? step_paddle(pr_q, r_up_s, r_dn_s) : pr_q;
            end
            U_BALL: begin
               if (ball_live) begin
                  wbx_q <= $signed({1'b0, ball_x_q}) + (vx_neg_q ? -SPD_B : SPD_B);
                  wby_q <= $signed({1'b0, ball_y_q}) + (vy_neg_q ? -SPD_B : SPD_B);
               end else begin
                  wbx_q <= $signed({1'b0, CX});
                  wby_q <= $signed({1'b0, CY});
               end
            end
            default: ;
         endcase
      end
   end

   // Walls first, then paddles (tested against the wall-corrected y), then misses.
   always_comb begin
      old_x  = $signed({1'b0, ball_x_q});
      by_c   = wby_q;
      vyn_c  = vy_neg_q;
      bx_c   = wbx_q;
      vxn_c  = vx_neg_q;
      miss_l = 1'b0;
      miss_r = 1'b0;
      if (by_c[10]) begin
         by_c  = '0;
         vyn_c = 1'b0;
      end else if (by_c > Y_MAX) begin
         by_c  = Y_MAX;
         vyn_c = 1'b1;
      end
      if (vx_neg_q && (bx_c <= XL_HIT) && (old_x >= XL_HIT) && overlap(by_c, wpl_q)) begin
         bx_c  = XL_HIT;
         vxn_c = 1'b0;
      end else if (!vx_neg_q && (bx_c >= XR_HIT) && (old_x <= XR_HIT) &&
                   overlap(by_c, wpr_q)) begin
         bx_c  = XR_HIT;
         vxn_c = 1'b1;
      end else if (bx_c[10]) begin
         miss_l = 1'b1;
      end else if (bx_c > X_MAX) begin
         miss_r = 1'b1;
      end
   end

   always_ff @(posedge clock_25M or negedge reset_n) begin
      if (!reset_n) begin
         ball_x_q    <= CX;
         ball_y_q    <= CY;
         pl_q        <= P_INIT;
         pr_q        <= P_INIT;
         score_l_q   <= '0;
         score_r_q   <= '0;
         vx_neg_q    <= 1'b0;
         vy_neg_q    <= 1'b0;
         serve_neg_q <= 1'b0;
         cnt_q       <= '0;
      end else if (upd_q == U_COLLIDE) begin
         pl_q <= wpl_q;
         pr_q <= wpr_q;
         if (restart) begin
            score_l_q   <= '0;
            score_r_q   <= '0;
            cnt_q       <= '0;
            serve_neg_q <= 1'b0;
         end
         if (state_q == SERVE) begin
            if (launch) begin
               vx_neg_q <= serve_neg_q;
               vy_neg_q <= 1'b0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
         if (ball_live && !score_pt) begin
            ball_x_q <= bx_c[9:0];
            ball_y_q <= by_c[9:0];
            vx_neg_q <= vxn_c;
            vy_neg_q <= vyn_c;
         end else begin
            ball_x_q <= CX;
            ball_y_q <= CY;
         end
         // Next serve heads toward whoever conceded.
         if (score_pt) begin
            cnt_q <= '0;
            if (miss_l) begin
               score_r_q   <= sat_inc(score_r_q);
               serve_neg_q <= 1'b1;
            end else begin
               score_l_q   <= sat_inc(score_l_q);
               serve_neg_q <= 1'b0;
            end
         end
      end
   end

   assign ball_x      = ball_x_q;
   assign ball_y      = ball_y_q;
   assign paddle_l_y  = pl_q;
   assign paddle_r_y  = pr_q;
   assign score_l     = score_l_q;
   assign score_r     = score_r_q;
   assign game_state  = state_q;
   assign update_done = (upd_q == U_COMMIT);

endmodule

// File: doc/pong_ctrl.md
# pong_ctrl

Per-frame game controller for the pong design. It runs in the 25 MHz pixel-clock domain and owns the game state: serve/play/score sequencing, paddle and ball positions, wall/paddle collisions and scoring. Once per frame, at the start of vertical blank, it performs a short multi-cycle update. Its position and score outputs feed the pixel painter, which only compares them against `sx`/`sy`.

## Interface
Parameters:
- `H_RES`, 640: active width in pixels
- `V_RES`, 480: active height in pixels
- `BALL_SIZE`, 8: ball side length in pixels
- `PADDLE_W`, 8: paddle width
- `PADDLE_H`, 48: paddle height
- `PADDLE_XL`, 16: left paddle left edge x
- `PADDLE_XR`, 616: right paddle left edge x
- `BALL_SPEED`, 2: ball |vx| and |vy| in pixels/frame
- `PADDLE_SPEED`, 4: paddle pixels/frame
- `SERVE_FRAMES`, 60: frames the ball is held before launch
- `WIN_SCORE`, 9: points needed to win

Ports:
- `clock_25M`, in, 1: pixel clock; sole clock
- `reset_n`, in, 1: asynchronous, active-low reset
- `frame_tick`, in, 1: one-cycle pulse at `sx==0`, `sy==V_RES`
- `btn_l_up`, `btn_l_dn`, `btn_r_up`, `btn_r_dn`, `btn_start`, in, 1 each: asynchronous, active-high buttons
- `ball_x`, `ball_y`, out, 10: ball top-left corner
- `paddle_l_y`, `paddle_r_y`, out, 10: paddle top edges
- `score_l`, `score_r`, out, 4: player scores
- `game_state`, out, 3: encoded FSM state
- `update_done`, out, 1: one-cycle pulse when new outputs are committed

## Operation
- Buttons pass through a 2-flop synchronizer. The FSM samples them only on update cycles.
- Game FSM states: IDLE, SERVE, PLAY, OVER. Transitions are evaluated only during a frame update.
  - IDLE: ball centred at (316,236). Synchronized `btn_start`=1 → SERVE; clear scores; clear serve counter.
  - SERVE: ball held centred; paddles move. Counter increments per frame. When count reaches `SERVE_FRAMES`-1 → PLAY, vy=+`BALL_SPEED`, vx set to serve direction.
  - PLAY: ball and paddles move; collisions are resolved.
  - On a miss → SERVE with the scorer's score incremented. If the new score equals `WIN_SCORE` → OVER instead.
  - OVER: positions frozen. `btn_start` → SERVE with scores cleared.
- Serve direction:
  - First serve after reset or start goes right (vx=+`BALL_SPEED`).
  - Later serves go toward the player who conceded.
- Update sequencer, started by `frame_tick` when in U_IDLE: U_IDLE → U_PADDLE → U_BALL → U_COLLIDE → U_COMMIT → U_IDLE.
  - Working copies are computed in U_PADDLE through U_COLLIDE.
  - Outputs and `update_done` change only in U_COMMIT.
- Paddles:
  - up=1, dn=0 subtracts `PADDLE_SPEED`; dn=1, up=0 adds it; both or neither: no move.
  - Result clamped to [0, `V_RES`-`PADDLE_H`].
- Arithmetic: next positions are computed as 11-bit signed values so underflow and overflow are detectable. All stored positions are 10-bit unsigned.
- Ball collisions in PLAY (U_COLLIDE):
  - Top/bottom walls: y<0 → y=0, vy=+; y>`V_RES`-`BALL_SIZE` → y=`V_RES`-`BALL_SIZE`, vy=−.
  - Left paddle hit requires all of: vx<0, x ≤ `PADDLE_XL`+`PADDLE_W`, old x ≥ `PADDLE_XL`+`PADDLE_W`, and vertical overlap. Vertical overlap means ball_y+`BALL_SIZE` > paddle_y and ball_y < paddle_y+`PADDLE_H`. Response: x=`PADDLE_XL`+`PADDLE_W`, vx=+. The right paddle is mirrored, with x clamped to `PADDLE_XR`-`BALL_SIZE`.
  - Miss: x<0 → point to right player; x>`H_RES`-`BALL_SIZE` → point to left player.
  - Order of checks: walls first, then paddle hit, then miss. A wall bounce and a paddle hit in the same frame are both applied.

## Timing
- Reset values:
  - ball (316,236); both paddles 216; scores 0
  - game_state IDLE; `update_done` 0; vx=+`BALL_SPEED`, vy=+`BALL_SPEED`; serve counter 0
- Latency: `frame_tick` in cycle N → outputs updated and `update_done`=1 in cycle N+4. Outputs are stable for the rest of the frame.
- Button-to-effect: synchronizer delay (2 cycles), then the next `frame_tick`.
- A `frame_tick` that arrives while the sequencer is not in U_IDLE is ignored.
- Reset asserted mid-update: all state returns to reset values at once; no partial commit.
- Scores saturate at `WIN_SCORE`; increments happen only on PLAY→SERVE/OVER.

## Structure
- `pong_pkg` holds:
  - `game_state_t` enum: IDLE=0, SERVE=1, PLAY=2, OVER=3
  - `upd_state_t` enum
  - shared `H_RES`/`V_RES` localparams, also used by `vga` and the painter
- Sub-module `btn_sync`: parameterized-width 2-flop synchronizer, same clock and reset. Instantiated once, 5 bits wide.

## Test plan
- Reset held 3 cycles, then released → ball (316,236), paddles 216, scores 0, state IDLE; no `update_done` until the first `frame_tick`.
- `btn_start` high, then one `frame_tick` → SERVE. After 60 further ticks → PLAY, and `ball_x` rises by 2 per tick with `update_done` 4 cycles after each tick.
- `btn_l_up` held for 60 frames from paddle_l_y=216 → clamps at 0. Both buttons pressed → paddle unchanged.
- Ball at (26,100), vx=−2, paddle_l_y=80 → after one tick, ball_x=24 and vx=+2 (bounce). With paddle_l_y=300 instead → ball continues, and the miss gives score_r+1 and state SERVE.
- Ball at y=1, vy=−2 → y=0, vy=+2. Ball at y=471, vy=+2 → y=472, vy=−2.
- score_l=8 and the right player misses → score_l=9, state OVER, positions frozen. `btn_start` → scores 0, state SERVE.
